// File: rtl/pipelined_addsub_if.sv
// Valid/ready operand and result bundle for pipelined_addsub.
// The slave modport is the adder side; the master modport is the producer/consumer side.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH:0]   result;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, result
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, result
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one SW-bit carry slice is resolved per stage,
// and all stages advance together under a single global stall.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic            clk,
    input  logic            rst,
    pipelined_addsub_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Subtraction is a + ~b + 1; a borrow-in removes that +1.
    assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
    assign w_c0      = bus.sub ? ~bus.cin : bus.cin;
    assign w_advance = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_advance;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_s_in;
        logic [WIDTH-1:0] w_s_out;
        logic             w_c;
        logic             w_v;
        logic [SW:0]      w_slice;
        logic             r_v;
        logic             r_c;
        logic [WIDTH-1:0] r_s;

        if (gi == 0) begin : g_head
            assign w_a    = bus.a;
            assign w_b    = w_b_eff;
            assign w_c    = w_c0;
            assign w_v    = bus.in_valid;
            assign w_s_in = '0;
        end else begin : g_body
            assign w_a    = g_stage[gi-1].g_ops.r_a;
            assign w_b    = g_stage[gi-1].g_ops.r_b;
            assign w_c    = g_stage[gi-1].r_c;
            assign w_v    = g_stage[gi-1].r_v;
            assign w_s_in = g_stage[gi-1].r_s;
        end

        assign w_slice = {1'b0, w_a[gi*SW +: SW]} + {1'b0, w_b[gi*SW +: SW]} + (SW+1)'(w_c);

        always_comb begin
            w_s_out = w_s_in;
            w_s_out[gi*SW +: SW] = w_slice[SW-1:0];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_advance) begin
                r_v <= w_v;
                r_c <= w_slice[SW];
                r_s <= w_s_out;
            end
        end

        if (gi < STAGES - 1) begin : g_ops
            // Operands still to be summed ride along with the partial result.
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_advance) begin
                    r_a <= w_a;
                    r_b <= w_b;
                end
            end
        end else begin : g_last
            logic r_ovf;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_advance) begin
                    r_ovf <= (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_s_out[WIDTH-1] != w_a[WIDTH-1]);
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].r_v;
    assign bus.sum       = g_stage[STAGES-1].r_s;
    assign bus.cout      = g_stage[STAGES-1].r_c;
    assign bus.ovf       = g_stage[STAGES-1].g_last.r_ovf;
    assign bus.result    = {g_stage[STAGES-1].r_c, g_stage[STAGES-1].r_s};
endmodule
